// File: rtl/ps2_host_cmd_ctrl.sv
// Host-side PS/2 command sequencer: arbitrates keyboard-reset and LED requests,
// feeds command bytes to the transmitter and tracks the ACK/RESEND/BAT replies.
module ps2_host_cmd_ctrl #(
  parameter int ACK_TIMEOUT = 2_500_000,
  parameter int BAT_TIMEOUT = 25_000_000,
  parameter int MAX_RETRY   = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rst_req,
  input  logic       led_req,
  input  logic [2:0] led_val,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  input  logic       tx_ready,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       rx_owned,
  output logic       busy,
  output logic       rst_done,
  output logic       led_done,
  output logic       err
);

  localparam int TMAX = (BAT_TIMEOUT > ACK_TIMEOUT) ? BAT_TIMEOUT : ACK_TIMEOUT;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int RW   = $clog2(MAX_RETRY + 2);
  localparam logic [TW-1:0] ACK_T = TW'(ACK_TIMEOUT);
  localparam logic [TW-1:0] BAT_T = TW'(BAT_TIMEOUT);
  localparam logic [RW-1:0] MAX_R = RW'(MAX_RETRY);

  localparam logic [7:0] CMD_RESET = 8'hFF;
  localparam logic [7:0] CMD_LED   = 8'hED;
  localparam logic [7:0] RSP_ACK   = 8'hFA;
  localparam logic [7:0] RSP_RSND  = 8'hFE;
  localparam logic [7:0] RSP_BAT   = 8'hAA;
  localparam logic [7:0] RSP_BFAIL = 8'hFC;

  typedef enum logic [1:0] {IDLE, SEND, WAIT_ACK, WAIT_BAT} state_t;

  state_t          state_q, state_d;
  logic            rst_pend_q, rst_pend_d;
  logic            led_pend_q, led_pend_d;
  logic [2:0]      led_val_q, led_val_d;
  logic [2:0]      led_cur_q, led_cur_d;
  logic            cmd_led_q, cmd_led_d;
  logic            step_q, step_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic [RW-1:0]   retry_q, retry_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            err_q, err_d;
  logic            rst_done_q, rst_done_d;
  logic            led_done_q, led_done_d;
  logic            nak;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      rst_pend_q <= 1'b0;
      led_pend_q <= 1'b0;
      led_val_q  <= 3'b0;
      led_cur_q  <= 3'b0;
      cmd_led_q  <= 1'b0;
      step_q     <= 1'b0;
      tx_data_q  <= 8'h00;
      retry_q    <= '0;
      timer_q    <= '0;
      err_q      <= 1'b0;
      rst_done_q <= 1'b0;
      led_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rst_pend_q <= rst_pend_d;
      led_pend_q <= led_pend_d;
      led_val_q  <= led_val_d;
      led_cur_q  <= led_cur_d;
      cmd_led_q  <= cmd_led_d;
      step_q     <= step_d;
      tx_data_q  <= tx_data_d;
      retry_q    <= retry_d;
      timer_q    <= timer_d;
      err_q      <= err_d;
      rst_done_q <= rst_done_d;
      led_done_q <= led_done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rst_pend_d = rst_pend_q | rst_req;
    led_pend_d = led_pend_q | led_req;
    led_val_d  = led_req ? led_val : led_val_q;
    led_cur_d  = led_cur_q;
    cmd_led_d  = cmd_led_q;
    step_d     = step_q;
    tx_data_d  = tx_data_q;
    retry_d    = retry_q;
    timer_d    = (&timer_q) ? timer_q : timer_q + 1'b1;
    err_d      = err_q;
    rst_done_d = 1'b0;
    led_done_d = 1'b0;
    nak        = 1'b0;

    case (state_q)
      IDLE: begin
        timer_d = '0;
        retry_d = '0;
        step_d  = 1'b0;
        if (rst_pend_q || rst_req) begin
          state_d    = SEND;
          cmd_led_d  = 1'b0;
          tx_data_d  = CMD_RESET;
          err_d      = 1'b0;
          rst_pend_d = 1'b0;
        end else if (led_pend_q || led_req) begin
          state_d    = SEND;
          cmd_led_d  = 1'b1;
          led_cur_d  = led_val_d;   // snapshot so later led_req cannot alter the in-flight byte
          tx_data_d  = CMD_LED;
          err_d      = 1'b0;
          led_pend_d = 1'b0;
        end
      end

      SEND: begin
        if (tx_ready) begin
          state_d = WAIT_ACK;
          timer_d = '0;
        end
      end

      WAIT_ACK: begin
        // A received byte in the expiry cycle wins; the saturated timer re-fires next cycle.
        if (rx_valid && rx_data == RSP_ACK) begin
          retry_d = '0;
          timer_d = '0;
          if (!cmd_led_q) begin
            state_d = WAIT_BAT;
          end else if (!step_q) begin
            step_d    = 1'b1;
            tx_data_d = {5'b0, led_cur_q};
            state_d   = SEND;
          end else begin
            state_d    = IDLE;
            led_done_d = 1'b1;
          end
        end else if (rx_valid) begin
          nak = (rx_data == RSP_RSND);
        end else begin
          nak = (timer_q >= ACK_T);
        end
        if (nak) begin
          if (retry_q < MAX_R) begin
            retry_d = retry_q + 1'b1;
            timer_d = '0;
            state_d = SEND;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end

      WAIT_BAT: begin
        if (rx_valid) begin
          if (rx_data == RSP_BAT) begin
            rst_done_d = 1'b1;
            state_d    = IDLE;
          end else if (rx_data == RSP_BFAIL) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end else if (timer_q >= BAT_T) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign tx_valid = (state_q == SEND);
  assign tx_data  = tx_data_q;
  assign busy     = (state_q != IDLE);
  assign rx_owned = busy;   // SEND is always the first non-idle state, so ownership matches busy
  assign rst_done = rst_done_q;
  assign led_done = led_done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_ps2_host_cmd_ctrl.sv
// Directed bench for ps2_host_cmd_ctrl with shortened timeouts.
module tb_ps2_host_cmd_ctrl;
  localparam int ACK_T = 200;
  localparam int BAT_T = 3000;
  localparam int MAXR  = 3;

  logic       clk = 0;
  logic       reset = 1;
  logic       rst_req = 0, led_req = 0;
  logic [2:0] led_val = 0;
  logic       tx_valid, tx_ready = 0;
  logic [7:0] tx_data;
  logic       rx_valid = 0;
  logic [7:0] rx_data = 0;
  logic       rx_owned, busy, rst_done, led_done, err;

  int errors = 0, checks = 0;
  int led_cnt = 0, rst_cnt = 0;
  int w, lc, rc;

  ps2_host_cmd_ctrl #(.ACK_TIMEOUT(ACK_T), .BAT_TIMEOUT(BAT_T), .MAX_RETRY(MAXR)) dut (
    .clk(clk), .reset(reset), .rst_req(rst_req), .led_req(led_req), .led_val(led_val),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_owned(rx_owned), .busy(busy),
    .rst_done(rst_done), .led_done(led_done), .err(err));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (led_done) led_cnt <= led_cnt + 1;
    if (rst_done) rst_cnt <= rst_cnt + 1;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for tx_valid, check the byte, accept it for one cycle.
  task automatic send_expect(input logic [7:0] exp, input string tag, output int waited);
    waited = 0;
    while (tx_valid !== 1'b1 && waited < 4000) begin
      tick();
      waited++;
    end
    chk({tag, "_txv"}, tx_valid, 1'b1);
    chk({tag, "_data"}, tx_data, exp);
    tx_ready = 1;
    tick();
    tx_ready = 0;
    chk({tag, "_drop"}, tx_valid, 1'b0);
  endtask

  task automatic rx(input logic [7:0] b);
    rx_data = b; rx_valid = 1;
    tick();
    rx_valid = 0;
  endtask

  initial begin
    tick(); tick();
    chk("rst_txv", tx_valid, 0); chk("rst_txd", tx_data, 8'h00);
    chk("rst_own", rx_owned, 0); chk("rst_busy", busy, 0);
    chk("rst_rd", rst_done, 0); chk("rst_ld", led_done, 0); chk("rst_err", err, 0);
    reset = 0;
    tick();

    // 1: LED update 101
    led_val = 3'b101; led_req = 1; tick(); led_req = 0;
    chk("t1_busy", busy, 1); chk("t1_own", rx_owned, 1);
    send_expect(8'hED, "t1_ed", w);
    chk("t1_own_wait", rx_owned, 1);
    rx(8'hFA);
    send_expect(8'h05, "t1_05", w);
    lc = led_cnt;
    rx(8'hFA);
    chk("t1_ldone", led_done, 1); chk("t1_idle", busy, 0);
    chk("t1_own_lo", rx_owned, 0); chk("t1_err", err, 0);
    tick();
    chk("t1_ldone_cnt", led_cnt - lc, 1);
    chk("t1_ldone_lo", led_done, 0);

    // 2: keyboard reset, BAT 1000 cycles later
    rst_req = 1; tick(); rst_req = 0;
    send_expect(8'hFF, "t2_ff", w);
    rx(8'hFA);
    repeat (1000) tick();
    chk("t2_waitbat", busy, 1);
    chk("t2_noled", tx_valid, 0);
    rx(8'hAA);
    chk("t2_rdone", rst_done, 1); chk("t2_busy_lo", busy, 0); chk("t2_err", err, 0);

    // 3: two resends of ED
    tick();
    led_val = 3'b101; led_req = 1; tick(); led_req = 0;
    send_expect(8'hED, "t3_ed0", w); rx(8'hFE);
    send_expect(8'hED, "t3_ed1", w); rx(8'hFE);
    send_expect(8'hED, "t3_ed2", w); rx(8'hFA);
    send_expect(8'h05, "t3_05", w);
    rx(8'h12);                         // stray byte ignored
    chk("t3_ignore", busy, 1);
    rx(8'hFA);
    chk("t3_ldone", led_done, 1); chk("t3_err", err, 0);

    // 4: reset with no response -> 1+MAXR sends, then abort
    tick();
    rst_req = 1; tick(); rst_req = 0;
    send_expect(8'hFF, "t4_ff0", w);
    for (int i = 1; i <= MAXR; i++) begin
      send_expect(8'hFF, "t4_ffr", w);
      chk("t4_spacing", w, ACK_T + 1);
    end
    rc = rst_cnt;
    repeat (ACK_T) tick();
    chk("t4_still", busy, 1);
    tick();
    chk("t4_abort_busy", busy, 0); chk("t4_err", err, 1); chk("t4_notx", tx_valid, 0);
    tick();
    chk("t4_err_sticky", err, 1);
    led_val = 3'b011; led_req = 1; tick(); led_req = 0;
    chk("t4_err_clr", err, 0);
    send_expect(8'hED, "t4_ed", w); rx(8'hFA);
    send_expect(8'h03, "t4_03", w); rx(8'hFA);
    chk("t4_ldone", led_done, 1);
    chk("t4_no_rdone", rst_cnt - rc, 0);

    // 5: simultaneous requests, LED overwritten during reset
    tick();
    led_val = 3'b111; rst_req = 1; led_req = 1; tick(); rst_req = 0; led_req = 0;
    send_expect(8'hFF, "t5_ff", w);
    led_val = 3'b010; led_req = 1; tick(); led_req = 0;
    rx(8'hFA);
    rx(8'hAA);
    chk("t5_rdone", rst_done, 1); chk("t5_gap_busy", busy, 0); chk("t5_gap_txv", tx_valid, 0);
    send_expect(8'hED, "t5_ed", w);
    chk("t5_gap_len", w, 1);
    rx(8'hFA);
    send_expect(8'h02, "t5_02", w);
    lc = led_cnt;
    rx(8'hFA);
    chk("t5_ldone", led_done, 1);
    repeat (20) tick();
    chk("t5_single", busy, 0); chk("t5_single_tx", tx_valid, 0);
    chk("t5_ldcnt", led_cnt - lc, 1);

    // 6: reset during WAIT_ACK of the data byte
    led_val = 3'b101; led_req = 1; tick(); led_req = 0;
    send_expect(8'hED, "t6_ed", w); rx(8'hFA);
    send_expect(8'h05, "t6_05", w);
    lc = led_cnt;
    reset = 1; #2;
    chk("t6_txv", tx_valid, 0); chk("t6_txd", tx_data, 8'h00); chk("t6_own", rx_owned, 0);
    chk("t6_busy", busy, 0); chk("t6_ld", led_done, 0); chk("t6_err", err, 0);
    tick();
    reset = 0;
    tick();
    rx(8'hFA);
    chk("t6_stray_ld", led_done, 0); chk("t6_stray_busy", busy, 0);
    repeat (5) tick();
    chk("t6_stray_tx", tx_valid, 0);
    chk("t6_ldcnt", led_cnt - lc, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
